vn_extrinsic_sub: RTL and testbench

//  Variable-node extrinsic stage for the LDPC decoder; sits downstream of the running-sum accumulator.

---
 rtl/vn_extrinsic_sub_if.sv | 26 ++
 rtl/vn_extrinsic_sub.sv | 158 +++++++++++++++
 tb/tb_vn_extrinsic_sub.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vn_extrinsic_sub_if.sv
// Message/sum stream into the extrinsic subtractor and the extrinsic stream out of it.
// master drives the message and sum side; slave is the subtractor.
interface vn_extrinsic_sub_if #(
    parameter int DW = 16
);
    logic signed [DW-1:0] i_data;
    logic                 i_val;
    logic [2:0]           i_init;
    logic signed [DW-1:0] i_sum;
    logic                 i_sum_val;
    logic signed [DW-1:0] o_data;
    logic                 o_val;
    logic                 o_last;
    logic                 o_busy;
    logic                 o_ovf;

    modport master (
        output i_data, i_val, i_init, i_sum, i_sum_val,
        input  o_data, o_val, o_last, o_busy, o_ovf
    );

    modport slave (
        input  i_data, i_val, i_init, i_sum, i_sum_val,
        output o_data, o_val, o_last, o_busy, o_ovf
    );
endinterface

// File: rtl/vn_extrinsic_sub.sv
// Purpose: buffers one node group, then emits group total minus each entry in input order (VN_EXTR_SAT_EN selects saturation over wrap).
// Latency: first o_val one cycle after the i_sum_val edge, then count contiguous beats; outputs registered.
// Backpressure: none; inputs are ignored while emitting (o_busy).
module vn_extrinsic_sub #(
    parameter int DW    = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input logic              clk,
    input logic              xrst,
    vn_extrinsic_sub_if.slave bus
);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [AW-1:0]        rd, rd_nxt;
    logic signed [DW-1:0] sum_q, sum_nxt;
    logic                 ovf, ovf_nxt;

    logic signed [DW-1:0] o_data_q, o_data_nxt;
    logic                 o_val_q, o_val_nxt;
    logic                 o_last_q, o_last_nxt;
    logic                 o_busy_q, o_busy_nxt;

    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic signed [DW-1:0] mem [DEPTH];

    logic signed [DW-1:0] rd_dat;
    logic signed [DW:0]   diff;
    logic signed [DW-1:0] ext;
    logic                 is_init;
    logic                 rd_is_last;

    assign is_init    = (bus.i_init == 3'd1);
    assign rd_dat     = mem[rd];
    assign rd_is_last = ({1'b0, rd} == (cnt - CW'(1)));

    // One extra bit so the difference of two DW-bit values never overflows before reduction.
    assign diff = {sum_q[DW-1], sum_q} - {rd_dat[DW-1], rd_dat};

    always_comb begin
        ext = diff[DW-1:0];
`ifdef VN_EXTR_SAT_EN
        if (diff[DW] != diff[DW-1]) begin
            ext = diff[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
`endif
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        rd_nxt     = rd;
        sum_nxt    = sum_q;
        ovf_nxt    = ovf;
        wr_en      = 1'b0;
        wr_addr    = '0;
        o_data_nxt = o_data_q;
        o_val_nxt  = 1'b0;
        o_last_nxt = 1'b0;
        o_busy_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (bus.i_val && is_init) begin
                    wr_en     = 1'b1;
                    wr_addr   = '0;
                    cnt_nxt   = CW'(1);
                    state_nxt = LOAD;
                end
            end

            LOAD: begin
                if (bus.i_val) begin
                    if (is_init) begin
                        wr_en   = 1'b1;
                        wr_addr = '0;
                        cnt_nxt = CW'(1);
                    end else if (cnt == CW'(DEPTH)) begin
                        ovf_nxt = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        wr_addr = cnt[AW-1:0];
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                // A message in the same cycle is written this edge, so cnt_nxt already counts it.
                if (bus.i_sum_val) begin
                    sum_nxt   = bus.i_sum;
                    rd_nxt    = '0;
                    state_nxt = EMIT;
                end
            end

            EMIT: begin
                o_val_nxt  = 1'b1;
                o_busy_nxt = 1'b1;
                o_data_nxt = ext;
                rd_nxt     = rd + AW'(1);
                if (rd_is_last) begin
                    o_last_nxt = 1'b1;
                    cnt_nxt    = '0;
                    rd_nxt     = '0;
                    state_nxt  = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state    <= IDLE;
            cnt      <= '0;
            rd       <= '0;
            sum_q    <= '0;
            ovf      <= 1'b0;
            o_data_q <= '0;
            o_val_q  <= 1'b0;
            o_last_q <= 1'b0;
            o_busy_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rd       <= rd_nxt;
            sum_q    <= sum_nxt;
            ovf      <= ovf_nxt;
            o_data_q <= o_data_nxt;
            o_val_q  <= o_val_nxt;
            o_last_q <= o_last_nxt;
            o_busy_q <= o_busy_nxt;
        end
    end

    // Buffer contents need no reset: cnt gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= bus.i_data;
        end
    end

    assign bus.o_data = o_data_q;
    assign bus.o_val  = o_val_q;
    assign bus.o_last = o_last_q;
    assign bus.o_busy = o_busy_q;
    assign bus.o_ovf  = ovf;
endmodule

// File: tb/tb_vn_extrinsic_sub.sv
// Directed bench for vn_extrinsic_sub: hand-computed extrinsic sequences, overflow, restart, reset abort.
// Expected saturation results follow VN_EXTR_SAT_EN as seen by the bench compile.
module tb_vn_extrinsic_sub;
    logic clk;
    logic xrst;
    int   vecs = 0;
    int   errs = 0;

    vn_extrinsic_sub_if #(.DW(16)) bus ();

    vn_extrinsic_sub #(.DW(16), .DEPTH(8), .AW(3)) dut (
        .clk  (clk),
        .xrst (xrst),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic msg(input int d, input logic [2:0] ini);
        bus.i_data = 16'(d);
        bus.i_init = ini;
        bus.i_val  = 1'b1;
        tick();
        bus.i_val  = 1'b0;
        bus.i_init = 3'd0;
    endtask

    task automatic sum_pulse(input int s);
        bus.i_sum     = 16'(s);
        bus.i_sum_val = 1'b1;
        tick();
        bus.i_sum_val = 1'b0;
    endtask

    task automatic test_reset();
        xrst          = 1'b0;
        bus.i_data    = '0;
        bus.i_val     = 1'b0;
        bus.i_init    = 3'd0;
        bus.i_sum     = '0;
        bus.i_sum_val = 1'b0;
        tick();
        tick();
        vecs++;
        if ({bus.o_val, bus.o_last, bus.o_busy, bus.o_ovf, bus.o_data} !== 20'h0) begin
            errs++;
            $display("FAIL reset_state got %h exp %h",
                     {bus.o_val, bus.o_last, bus.o_busy, bus.o_ovf, bus.o_data}, 20'h0);
        end
        xrst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int e [3] = '{4, 12, 2};
        msg(5, 3'd1);
        msg(-3, 3'd0);
        msg(7, 3'd0);
        sum_pulse(9);
        for (int k = 0; k < 3; k++) begin
            tick();
            vecs++;
            if ({bus.o_val, bus.o_last, bus.o_busy, bus.o_data} !== {1'b1, k == 2, 1'b1, 16'(e[k])}) begin
                errs++;
                $display("FAIL basic_beat%0d got v%b l%b b%b %0d exp v1 l%0d b1 %0d",
                         k, bus.o_val, bus.o_last, bus.o_busy, bus.o_data, k == 2, e[k]);
            end
        end
        tick();
        vecs++;
        if ({bus.o_val, bus.o_last, bus.o_busy, bus.o_data} !== {3'b000, 16'sd2}) begin
            errs++;
            $display("FAIL basic_after got v%b l%b b%b %0d exp v0 l0 b0 2",
                     bus.o_val, bus.o_last, bus.o_busy, bus.o_data);
        end
    endtask

    task automatic test_saturation();
        int s [2] = '{32767, -32768};
        int m [2] = '{-32768, 32767};
`ifdef VN_EXTR_SAT_EN
        int e [2] = '{32767, -32768};
`else
        int e [2] = '{-1, 1};
`endif
        for (int k = 0; k < 2; k++) begin
            msg(m[k], 3'd1);
            sum_pulse(s[k]);
            tick();
            vecs++;
            if ({bus.o_val, bus.o_last, bus.o_data} !== {2'b11, 16'(e[k])}) begin
                errs++;
                $display("FAIL sat_case%0d got v%b l%b %0d exp v1 l1 %0d",
                         k, bus.o_val, bus.o_last, bus.o_data, e[k]);
            end
            tick();
        end
    endtask

    task automatic test_overflow();
        msg(1, 3'd1);
        for (int k = 2; k <= 9; k++) msg(k, 3'd0);
        vecs++;
        if (bus.o_ovf !== 1'b1) begin
            errs++;
            $display("FAIL ovf_flag got %b exp 1", bus.o_ovf);
        end
        sum_pulse(45);
        for (int k = 0; k < 8; k++) begin
            tick();
            vecs++;
            if ({bus.o_val, bus.o_last, bus.o_data} !== {1'b1, k == 7, 16'(44 - k)}) begin
                errs++;
                $display("FAIL ovf_beat%0d got v%b l%b %0d exp v1 l%0d %0d",
                         k, bus.o_val, bus.o_last, bus.o_data, k == 7, 44 - k);
            end
        end
        tick();
        vecs++;
        if ({bus.o_val, bus.o_ovf} !== 2'b01) begin
            errs++;
            $display("FAIL ovf_sticky got v%b ovf%b exp v0 ovf1", bus.o_val, bus.o_ovf);
        end
    endtask

    task automatic test_restart();
        msg(10, 3'd1);
        msg(20, 3'd0);
        msg(4, 3'd1);
        sum_pulse(4);
        tick();
        vecs++;
        if ({bus.o_val, bus.o_last, bus.o_data} !== {2'b11, 16'sd0}) begin
            errs++;
            $display("FAIL restart_beat got v%b l%b %0d exp v1 l1 0", bus.o_val, bus.o_last, bus.o_data);
        end
        tick();
        vecs++;
        if (bus.o_val !== 1'b0) begin
            errs++;
            $display("FAIL restart_single got v%b exp v0", bus.o_val);
        end
        sum_pulse(100);
        for (int k = 0; k < 3; k++) begin
            vecs++;
            if ({bus.o_val, bus.o_busy} !== 2'b00) begin
                errs++;
                $display("FAIL idle_sum%0d got v%b b%b exp v0 b0", k, bus.o_val, bus.o_busy);
            end
            tick();
        end
    endtask

    task automatic test_reset_abort();
        msg(1, 3'd1);
        msg(2, 3'd0);
        msg(3, 3'd0);
        sum_pulse(6);
        tick();
        vecs++;
        if ({bus.o_val, bus.o_data} !== {1'b1, 16'sd5}) begin
            errs++;
            $display("FAIL abort_first got v%b %0d exp v1 5", bus.o_val, bus.o_data);
        end
        xrst = 1'b0;
        #1;
        vecs++;
        if ({bus.o_val, bus.o_last, bus.o_busy, bus.o_ovf, bus.o_data} !== 20'h0) begin
            errs++;
            $display("FAIL abort_outputs got %h exp %h",
                     {bus.o_val, bus.o_last, bus.o_busy, bus.o_ovf, bus.o_data}, 20'h0);
        end
        tick();
        tick();
        xrst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            vecs++;
            if (bus.o_val !== 1'b0) begin
                errs++;
                $display("FAIL abort_quiet%0d got v%b exp v0", k, bus.o_val);
            end
        end
        msg(8, 3'd1);
        sum_pulse(8);
        tick();
        vecs++;
        if ({bus.o_val, bus.o_last, bus.o_data} !== {2'b11, 16'sd0}) begin
            errs++;
            $display("FAIL abort_newgrp got v%b l%b %0d exp v1 l1 0", bus.o_val, bus.o_last, bus.o_data);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int e [2] = '{3, 2};
        int f [2] = '{60, 40};
        msg(2, 3'd1);
        bus.i_data    = 16'sd3;
        bus.i_init    = 3'd0;
        bus.i_val     = 1'b1;
        bus.i_sum     = 16'sd5;
        bus.i_sum_val = 1'b1;
        tick();
        // Junk held for the whole emit window must be ignored.
        bus.i_data = 16'sd100;
        bus.i_sum  = 16'sd77;
        for (int k = 0; k < 2; k++) begin
            tick();
            vecs++;
            if ({bus.o_val, bus.o_last, bus.o_data} !== {1'b1, k == 1, 16'(e[k])}) begin
                errs++;
                $display("FAIL same_cycle_beat%0d got v%b l%b %0d exp v1 l%0d %0d",
                         k, bus.o_val, bus.o_last, bus.o_data, k == 1, e[k]);
            end
        end
        bus.i_val     = 1'b0;
        bus.i_sum_val = 1'b0;
        tick();
        vecs++;
        if (bus.o_val !== 1'b0) begin
            errs++;
            $display("FAIL emit_ignore got v%b exp v0", bus.o_val);
        end
        msg(40, 3'd1);
        msg(60, 3'd0);
        sum_pulse(100);
        for (int k = 0; k < 2; k++) begin
            tick();
            vecs++;
            if ({bus.o_val, bus.o_last, bus.o_data} !== {1'b1, k == 1, 16'(f[k])}) begin
                errs++;
                $display("FAIL next_grp_beat%0d got v%b l%b %0d exp v1 l%0d %0d",
                         k, bus.o_val, bus.o_last, bus.o_data, k == 1, f[k]);
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_overflow();
        test_restart();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
